// File: rtl/multu_hilo_pkg.sv
// multu_hilo_pkg: function codes, FSM encoding and the shift-add step shared by the execution unit.
package multu_hilo_pkg;
  localparam logic [5:0] SLL   = 6'b000000;
  localparam logic [5:0] SRL   = 6'b000010;
  localparam logic [5:0] SRA   = 6'b000011;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] ADD   = 6'b100000;
  localparam logic [5:0] ADDU  = 6'b100001;
  localparam logic [5:0] SUB   = 6'b100010;
  localparam logic [5:0] SUBU  = 6'b100011;
  localparam logic [5:0] AND   = 6'b100100;
  localparam logic [5:0] OR    = 6'b100101;
  localparam logic [5:0] XOR   = 6'b100110;
  localparam logic [5:0] NOR   = 6'b100111;
  localparam logic [5:0] SLT   = 6'b101010;
  localparam logic [5:0] SLTU  = 6'b101011;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;
  // One iteration: conditional 33-bit add into the upper half (carry kept in bit 64), then logical shift right.
  function automatic logic [64:0] mul_step(input logic [64:0] p, input logic [31:0] m);
    logic [32:0] sum;
    logic [64:0] t;
    sum = {1'b0, p[63:32]} + {1'b0, m};
    t = p[0] ? {sum, p[31:0]} : p;
    return t >> 1;
  endfunction
endpackage

// File: rtl/multu_hilo_hilo_reg.sv
// hilo_reg: HI/LO result registers with per-register write enables and the MFHI/MFLO read mux.
module hilo_reg
  import multu_hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [5:0]  sel_i,
  output logic [31:0] rd_o
);
  logic [31:0] hi_q, lo_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we_i) hi_q <= hi_i;
      if (lo_we_i) lo_q <= lo_i;
    end
  end
  always_comb rd_o = sel_i == MFHI ? hi_q : sel_i == MFLO ? lo_q : 32'b0;
endmodule

// File: rtl/multu_hilo.sv
// multu_hilo: 32-cycle shift-add 32x32 unsigned multiplier committing its 64-bit product to HI/LO.
module multu_hilo
  import multu_hilo_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        done
);
  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] mcand_q, mcand_d;
  logic [64:0] prod_q, prod_d, prod_nx;
  logic        start, commit;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end
  always_comb begin
    start   = Signal == MULTU;
    prod_nx = mul_step(prod_q, mcand_q);
    commit  = state_q == ST_RUN && count_q == 5'd31;
    state_d = state_q;
    count_d = count_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    // RUN ignores Signal and operand inputs; IDLE and DONE both accept a new start.
    if (state_q == ST_RUN) begin
      prod_d  = prod_nx;
      count_d = count_q + 5'd1;
      state_d = commit ? ST_DONE : ST_RUN;
    end else if (start) begin
      mcand_d = dataA;
      prod_d  = {33'b0, dataB};
      count_d = '0;
      state_d = ST_RUN;
    end else begin
      state_d = ST_IDLE;
    end
  end
  assign busy = state_q == ST_RUN;
  assign done = state_q == ST_DONE;
  hilo_reg u_hilo (
    .clk     (clk),
    .rst     (reset),
    .hi_we_i (commit),
    .lo_we_i (commit),
    .hi_i    (prod_nx[63:32]),
    .lo_i    (prod_nx[31:0]),
    .sel_i   (Signal),
    .rd_o    (dataOut)
  );
endmodule

// File: tb/tb_multu_hilo.sv
// tb_multu_hilo: directed checks of latency, products, HI/LO reads, reset abort and back-to-back starts.
module tb_multu_hilo;
  import multu_hilo_pkg::*;
  logic        clk = 0;
  logic        reset;
  logic [31:0] dataA, dataB, dataOut;
  logic [5:0]  Signal;
  logic        busy, done;
  int          errors = 0;
  int          checks = 0;
  multu_hilo dut (
    .clk     (clk),
    .reset   (reset),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    dataA = a;
    dataB = b;
    Signal = MULTU;
    tick();
    Signal = 6'h3f;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
  endtask
  task automatic test_reset();
    reset = 1;
    dataA = 32'h5;
    dataB = 32'h7;
    Signal = MULTU;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    Signal = MFHI;
    #1;
    checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL reset_dataout got=%h exp=0", dataOut); end
    Signal = 6'h3f;
    reset = 0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
  endtask
  task automatic test_small();
    int n;
    start(32'd3, 32'd5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL small_busy_start got=%b exp=1", busy); end
    wait_done(n);
    checks++; if (n !== 32) begin errors++; $display("FAIL small_latency got=%0d exp=32", n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL small_busy_done got=%b exp=0", busy); end
    Signal = MFHI;
    #1;
    checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL small_hi got=%h exp=00000000", dataOut); end
    Signal = MFLO;
    #1;
    checks++; if (dataOut !== 32'hF) begin errors++; $display("FAIL small_lo got=%h exp=0000000f", dataOut); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL small_done_pulse got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL small_idle got=%b exp=0", busy); end
  endtask
  task automatic test_max();
    int n;
    start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    checks++; if (n !== 32) begin errors++; $display("FAIL max_latency got=%0d exp=32", n); end
    Signal = MFHI;
    #1;
    checks++; if (dataOut !== 32'hFFFF_FFFE) begin errors++; $display("FAIL max_hi got=%h exp=fffffffe", dataOut); end
    Signal = MFLO;
    #1;
    checks++; if (dataOut !== 32'h1) begin errors++; $display("FAIL max_lo got=%h exp=00000001", dataOut); end
    tick();
  endtask
  task automatic test_read_during_run();
    int n;
    start(32'd3, 32'd5);
    wait_done(n);
    tick();
    start(32'h0001_0000, 32'h0001_0000);
    repeat (9) tick();
    Signal = MFLO;
    #1;
    checks++; if (dataOut !== 32'hF) begin errors++; $display("FAIL run_read_lo got=%h exp=0000000f", dataOut); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_read_busy got=%b exp=1", busy); end
    wait_done(n);
    checks++; if (n !== 23) begin errors++; $display("FAIL run_read_latency got=%0d exp=23", n); end
    Signal = MFHI;
    #1;
    checks++; if (dataOut !== 32'h1) begin errors++; $display("FAIL run_read_hi got=%h exp=00000001", dataOut); end
    Signal = MFLO;
    #1;
    checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL run_read_lo_new got=%h exp=00000000", dataOut); end
    tick();
  endtask
  task automatic test_reset_mid();
    bit seen = 0;
    start(32'd7, 32'd9);
    repeat (11) tick();
    Signal = MFHI;
    reset = 1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
    checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL abort_dataout got=%h exp=0", dataOut); end
    Signal = 6'h3f;
    tick();
    reset = 0;
    repeat (40) begin
      tick();
      seen |= done | busy;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_idle got=%b exp=0", seen); end
    Signal = MFHI;
    #1;
    checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL abort_hi got=%h exp=0", dataOut); end
    Signal = MFLO;
    #1;
    checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL abort_lo got=%h exp=0", dataOut); end
    Signal = 6'h3f;
  endtask
  task automatic test_back_to_back();
    int n, m;
    dataA = 32'd2;
    dataB = 32'd4;
    Signal = MULTU;
    tick();
    repeat (5) tick();
    dataA = 32'd0;
    dataB = 32'h1234_5678;
    wait_done(n);
    checks++; if (n !== 27) begin errors++; $display("FAIL b2b_latency1 got=%0d exp=27", n); end
    Signal = MFLO;
    #1;
    checks++; if (dataOut !== 32'd8) begin errors++; $display("FAIL b2b_lo1 got=%h exp=00000008", dataOut); end
    Signal = MULTU;
    tick();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_restart got=busy%b_done%b exp=busy1_done0", busy, done); end
    wait_done(m);
    checks++; if (m + 1 !== 33) begin errors++; $display("FAIL b2b_period got=%0d exp=33", m + 1); end
    Signal = MFHI;
    #1;
    checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL b2b_hi2 got=%h exp=0", dataOut); end
    Signal = MFLO;
    #1;
    checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL b2b_lo2 got=%h exp=0", dataOut); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_idle got=busy%b_done%b exp=busy0_done0", busy, done); end
  endtask
  task automatic test_non_mf();
    int n;
    start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    tick();
    Signal = SRL;
    #1;
    checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL nonmf_srl got=%h exp=0", dataOut); end
    Signal = ADDU;
    #1;
    checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL nonmf_addu got=%h exp=0", dataOut); end
    Signal = MFHI;
    #1;
    checks++; if (dataOut !== 32'hFFFF_FFFE) begin errors++; $display("FAIL nonmf_hi got=%h exp=fffffffe", dataOut); end
    Signal = MFLO;
    #1;
    checks++; if (dataOut !== 32'h1) begin errors++; $display("FAIL nonmf_lo got=%h exp=00000001", dataOut); end
  endtask
  initial begin
    test_reset();
    test_small();
    test_max();
    test_read_during_run();
    test_reset_mid();
    test_back_to_back();
    test_non_mf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multu_hilo.md
# multu_hilo

Sequential 32x32 unsigned multiplier with HI/LO result registers; it sits beside the shifter and the ALU in the execution unit and feeds the same result multiplexer. A MULTU function code starts a 32-cycle shift-add multiplication. The 64-bit product is committed to HI/LO at completion. MFHI/MFLO function codes place HI or LO on `dataOut`.

## Interface
- `MULTU`, 6'b011001, function code that starts a multiplication.
- `MFHI`, 6'b010000, function code that selects HI onto `dataOut`.
- `MFLO`, 6'b010010, function code that selects LO onto `dataOut`.
- `clk`  input  1  rising-edge clock; the block has one clock.
- `reset`  input  1  reset; asynchronous and active-high.
- `dataA`  input  32  multiplicand (unsigned).
- `dataB`  input  32  multiplier (unsigned).
- `Signal`  input  6  function code.
- `dataOut`  output  32  HI or LO per `Signal`; 0 otherwise.
- `busy`  output  1  multiplication in progress.
- `done`  output  1  one-cycle pulse when HI/LO are updated.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:** on a clock edge with `Signal==MULTU`:
  - latch `dataA` into the multiplicand register (32b);
  - load the product register (65b, including carry) with `{33'b0, dataB}`;
  - clear `count`;
  - go to RUN.
- **RUN:** each edge is one iteration.
  - If `product[0]==1`, replace `product[64:32]` with `product[63:32] + mcand`, a 33-bit add that keeps the carry.
  - Then shift the product register right logically by 1 and increment `count`.
  - After the iteration with `count==31`: write `product[63:32]` to HI and `product[31:0]` to LO, then go to DONE.
- **DONE:** lasts one cycle.
  - `Signal==MULTU` starts a new multiplication directly (DONE→RUN, operands latched as in IDLE).
  - Otherwise go to IDLE.
- `Signal` is ignored by the FSM while in RUN. Operand changes on `dataA`/`dataB` during RUN have no effect.
- `dataOut` is combinational from the HI/LO registers:
  - `Signal==MFHI` → HI;
  - `Signal==MFLO` → LO;
  - any other code → 32'b0.
- HI/LO change only at completion. MFHI/MFLO issued during RUN return the previous product.
- The product is exact for the full range: the maximum value, 0xFFFFFFFE_00000001, fits in 64 bits and the 33-bit add never overflows.

## Timing
- **Reset values:**
  - state IDLE;
  - HI=0, LO=0, `count`=0, product register 0;
  - `busy`=0, `done`=0;
  - `dataOut`=0 regardless of `Signal` while `reset` is high.
- **Reset mid-operation:** the operation is aborted and HI/LO are cleared. There is no partial commit.
- **Latency:**
  - MULTU is sampled at edge E0.
  - `busy`=1 from E0 through E32.
  - HI/LO are valid after edge E32; `done`=1 for the cycle after E32 (the DONE state).
  - MFHI/MFLO read the new values from that cycle on.
- **`busy`** = (state==RUN).
- **`done`** = (state==DONE). It is registered, exactly one cycle, with no consecutive repeats unless a back-to-back MULTU is issued.
- **Back-to-back:** MULTU held continuously gives one result every 33 cycles: 32 in RUN plus 1 in DONE.
- **MULTU in IDLE during the reset-release cycle:** not started while `reset` is high. The first start is at the first edge after deassertion.

## Structure
- Shared package holds:
  - the function-code constants MULTU, MFHI, MFLO (alongside SRL and the other ALU codes);
  - the state encoding (2b: IDLE, RUN, DONE).
- One sub-module: `hilo_reg`.
  - Holds the two 32-bit registers with async reset and write enable.
  - Contains the MFHI/MFLO read mux.
  - Is reused later when MTHI/MTLO are added.
- The top holds the FSM, 5-bit counter, multiplicand register, 65-bit product register and 33-bit adder.

## Test plan
- **Small product:** `dataA`=3, `dataB`=5, pulse MULTU in IDLE.
  - `busy` high for 32 cycles, then `done` for 1.
  - MFHI→0x00000000, MFLO→0x0000000F.
- **Maximum operands:** `dataA`=`dataB`=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 32 cycles.
- **Read during RUN:** after a completed 3×5, start 0x10000×0x10000 and read MFLO at cycle 10 of RUN.
  - Returns 0x0000000F, the old value.
  - After completion HI=0x00000001, LO=0x00000000.
- **Reset mid-operation:** start 7×9 and assert `reset` at RUN cycle 12.
  - Immediately `busy`=0, `done`=0, `dataOut`=0.
  - After release, MFHI/MFLO both read 0 and the state is IDLE.
- **Back-to-back with operand change:** hold MULTU with 2×4, then 0×0x12345678.
  - Change `dataA` mid-RUN: no effect on the result.
  - First result LO=8; second starts at the DONE cycle and gives HI=LO=0 exactly 33 cycles after the first `done`.
- **Non-MF codes:** with HI=0xFFFFFFFE and LO=1 loaded, drive `Signal`=6'b000010 (SRL) → `dataOut`=0.
